hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised, stateful hazard detector for the ID stage of the ARM pipeline.
//  Tracks the destination of every in-flight instruction in an internal shadow
//  shift register of DEPTH slots (slot 0 = EXE, slot 1 = MEM, ...), so the
//  unit no longer relies on destination/write-back signals tapped from the
//  pipeline registers. Generates a stall for RAW hazards, with or without
//  forwarding, and adds load-use detection.
// PARAMETERS
//  REG_ADDR_W  4   register-address width (16 architectural registers)
//  DEPTH       2   tracked stages after ID; legal range 1..4
//  CNT_W       16  stall-counter width (only with HAZARD_STALL_COUNTER_EN)
// PORTS
//  clk                input   1           pipeline clock, rising edge
//  rst                input   1           synchronous, active-high reset
//  forwardingEnabled  input   1           1 = forwarding unit active
//  freeze             input   1           pipeline frozen (memory wait); scoreboard holds
//  flush              input   1           taken branch; ID instruction becomes bubble
//  issueValid         input   1           ID holds a real instruction
//  src1               input   REG_ADDR_W  first source register (always compared)
//  src2               input   REG_ADDR_W  second source register
//  twoSrc             input   1           src2 is a real operand
//  issueDest          input   REG_ADDR_W  destination of the ID instruction
//  issueWb            input   1           ID instruction writes back
//  issueMemRead       input   1           ID instruction is a load
//  hazard             output  1           stall IF/ID and insert bubble (combinational)
//  stallCount         output  CNT_W       cycles stalled (only with macro)
// BEHAVIOUR
//  Slot contents: {valid, wb, memRead, dest}.
//  Reset: all slots valid=0. hazard=0 while rst=1 (forced mask).
//   stallCount=0.
//  Match(i): slot[i].valid & slot[i].wb & issueValid &
//            (src1==slot[i].dest | (twoSrc & src2==slot[i].dest)).
//  forwardingEnabled=0: hazard = OR over all i of Match(i).
//  forwardingEnabled=1: hazard = Match(0) & slot[0].memRead (load-use only).
//   Stalls exactly one cycle; the load then sits in slot 1 and is forwarded.
//  Shift on each rising edge with rst=0 & freeze=0:
//   slot[i] <= slot[i-1] for i=1..DEPTH-1; the oldest slot is discarded.
//   slot[0] <= issue info, valid = issueValid & ~hazard & ~flush.
//  freeze=1: all slots hold. hazard is still evaluated from the held state.
//  flush & hazard in the same cycle: a bubble enters slot 0; no double count.
//  Destination r15 is tracked like any other register.
//  src==dest on a bubble slot (valid=0) never matches.
//  Latency: hazard is valid in the same cycle as the src inputs. The scoreboard
//   reflects an issue one clock later.
//  rst mid-stall: next edge clears all slots, and hazard drops the same cycle rst rises.
//  forwardingEnabled may toggle at any cycle and takes effect combinationally.
// CONFIGURATION
//  HAZARD_STALL_COUNTER_EN defined:
//   - stallCount port exists.
//   - Increments on each edge with hazard=1, freeze=0 and rst=0.
//   - Saturates at 2^CNT_W-1.
//  HAZARD_STALL_COUNTER_EN undefined:
//   - Port and counter logic are absent.
//   - hazard behaviour is identical.
// TESTING
//  rst=1 2 cycles, then src1=issue values with no prior issue -> hazard=0,
//   all slots invalid.
//  fwd=0: issue ADD r3 (wb=1). Next cycle src1=3 -> hazard=1 for DEPTH=2
//   cycles, then 0.
//  fwd=1: LDR r5 issued. Next cycle src2=5, twoSrc=1 -> hazard=1 exactly
//   1 cycle. With twoSrc=0 -> hazard=0.
//  fwd=0: ADD r3 issued, then freeze=1 for 3 cycles with src1=3 -> hazard
//   stays 1 for 3+DEPTH cycles total.
//  flush=1 on the cycle ADD r7 issues. Next cycle src1=7 -> hazard=0 (bubble
//   entered). Assert rst mid-stall -> hazard=0 same cycle.
//  HAZARD_STALL_COUNTER_EN, CNT_W=4: 20 hazard cycles -> stallCount=15
//   (saturated). Cycles with freeze=1 are not counted.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW / load-use hazard detector with an internal shadow of in-flight destinations.
// Optional stall counter: define HAZARD_STALL_COUNTER_EN.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forwardingEnabled,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  issueValid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  twoSrc,
    input  logic [REG_ADDR_W-1:0] issueDest,
    input  logic                  issueWb,
    input  logic                  issueMemRead,
    output logic                  hazard
`ifdef HAZARD_STALL_COUNTER_EN
    ,
    output logic [CNT_W-1:0]      stallCount
`endif
);

    typedef struct packed {
        logic                  valid;
        logic                  wb;
        logic                  mem_read;
        logic [REG_ADDR_W-1:0] dest;
    } slot_t;

    slot_t            slots [DEPTH];
    logic [DEPTH-1:0] match;
    logic             raw_hazard;

    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = slots[i].valid & slots[i].wb & issueValid &
                       ((src1 == slots[i].dest) |
                        (twoSrc & (src2 == slots[i].dest)));
        end
    end

    // With forwarding only a load in EXE cannot be bypassed in time.
    always_comb begin
        raw_hazard = forwardingEnabled ? (match[0] & slots[0].mem_read)
                                       : (|match);
        hazard     = raw_hazard & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slots[i] <= slots[i-1];
            end
            slots[0].valid    <= issueValid & ~hazard & ~flush;
            slots[0].wb       <= issueWb;
            slots[0].mem_read <= issueMemRead;
            slots[0].dest     <= issueDest;
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCount <= '0;
        end else if (hazard && !freeze && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, counter saturation, random vs model.
// Counter checks are built only when HAZARD_STALL_COUNTER_EN is defined.
module tb_hazard_scoreboard;

    localparam int AW    = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    typedef struct {
        bit          rst;
        bit          fwd;
        bit          frz;
        bit          fl;
        bit          iv;
        bit [AW-1:0] s1;
        bit [AW-1:0] s2;
        bit          two;
        bit [AW-1:0] dst;
        bit          wb;
        bit          mr;
        bit          hz;
    } vec_t;

    typedef struct {
        bit          valid;
        bit          wb;
        bit          mr;
        bit [AW-1:0] dest;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst, forwardingEnabled, freeze, flush, issueValid;
    logic [AW-1:0] src1, src2, issueDest;
    logic          twoSrc, issueWb, issueMemRead;
    logic          hazard;
`ifdef HAZARD_STALL_COUNTER_EN
    logic [CNT_W-1:0] stallCount;
`endif

    int   total = 0;
    int   bad   = 0;
    rec_t q[$];
    int   m_cnt = 0;
    vec_t tab[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDR_W(AW),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .forwardingEnabled(forwardingEnabled),
        .freeze           (freeze),
        .flush            (flush),
        .issueValid       (issueValid),
        .src1             (src1),
        .src2             (src2),
        .twoSrc           (twoSrc),
        .issueDest        (issueDest),
        .issueWb          (issueWb),
        .issueMemRead     (issueMemRead),
        .hazard           (hazard)
`ifdef HAZARD_STALL_COUNTER_EN
        ,
        .stallCount       (stallCount)
`endif
    );

    function automatic vec_t mk(bit r, bit f, bit fz, bit fl, bit iv,
                                int s1, int s2, bit two, int d,
                                bit wb, bit mr, bit hz);
        vec_t v;
        v.rst = r;  v.fwd = f;  v.frz = fz; v.fl = fl; v.iv = iv;
        v.s1 = s1[AW-1:0]; v.s2 = s2[AW-1:0]; v.two = two;
        v.dst = d[AW-1:0]; v.wb = wb; v.mr = mr; v.hz = hz;
        return v;
    endfunction

    // Reference: in-flight producers, youngest first; any producer matching
    // a source blocks unless forwarding can bypass it (all but a fresh load).
    function automatic bit model_hz(vec_t v);
        bit any = 0;
        bit ld  = 0;
        if (v.rst) return 0;
        foreach (q[i]) begin
            bit m;
            m = q[i].valid && q[i].wb && v.iv &&
                (v.s1 == q[i].dest || (v.two && v.s2 == q[i].dest));
            if (m) any = 1;
            if (m && i == 0 && q[i].mr) ld = 1;
        end
        return v.fwd ? ld : any;
    endfunction

    task automatic model_clock(vec_t v, bit hz);
        rec_t n;
        if (v.rst) begin
            q.delete();
            n = '{0, 0, 0, 0};
            for (int i = 0; i < DEPTH; i++) q.push_back(n);
            m_cnt = 0;
        end else if (!v.frz) begin
            n = '{v.iv && !hz && !v.fl, v.wb, v.mr, v.dst};
            q.push_front(n);
            void'(q.pop_back());
            if (hz && m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(vec_t v, bit use_tab, string name);
        bit mh;
        rst = v.rst; forwardingEnabled = v.fwd; freeze = v.frz; flush = v.fl;
        issueValid = v.iv; src1 = v.s1; src2 = v.s2; twoSrc = v.two;
        issueDest = v.dst; issueWb = v.wb; issueMemRead = v.mr;
        #1;
        mh = model_hz(v);
        check(name, {31'd0, hazard}, {31'd0, use_tab ? v.hz : mh});
`ifdef HAZARD_STALL_COUNTER_EN
        if (!v.rst) check("stall_count", {28'd0, stallCount}, m_cnt);
`endif
        @(posedge clk);
        model_clock(v, mh);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) q.push_back('{0, 0, 0, 0});
        // rst fwd frz fl iv s1 s2 two dst wb mr hz
        tab.push_back(mk(1,0,0,0,1, 3,0,0, 3,1,0,0));
        tab.push_back(mk(1,0,0,0,1, 3,0,0, 3,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 3,0,0, 3,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 3,0,0, 4,1,0,1));
        tab.push_back(mk(0,0,0,0,1, 3,0,0, 4,1,0,1));
        tab.push_back(mk(0,0,0,0,1, 3,0,0, 4,1,0,0));
        tab.push_back(mk(0,0,0,0,0, 4,0,0, 0,0,0,0));
        tab.push_back(mk(0,0,0,0,0, 4,0,0, 0,0,0,0));
        // load-use with forwarding
        tab.push_back(mk(0,1,0,0,1, 0,0,0, 5,1,1,0));
        tab.push_back(mk(0,1,0,0,1, 1,5,1, 6,1,0,1));
        tab.push_back(mk(0,1,0,0,1, 1,5,1, 6,1,0,0));
        tab.push_back(mk(0,1,0,0,1, 0,0,0, 5,1,1,0));
        tab.push_back(mk(0,1,0,0,1, 1,5,0, 8,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 8,0,0, 9,0,0,1));
        tab.push_back(mk(0,1,0,0,1, 8,0,0, 9,0,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
        // freeze holds the producer in EXE
        tab.push_back(mk(0,0,0,0,1, 0,0,0, 3,1,0,0));
        tab.push_back(mk(0,0,1,0,1, 3,0,0,10,1,0,1));
        tab.push_back(mk(0,0,1,0,1, 3,0,0,10,1,0,1));
        tab.push_back(mk(0,0,1,0,1, 3,0,0,10,1,0,1));
        tab.push_back(mk(0,0,0,0,1, 3,0,0,10,1,0,1));
        tab.push_back(mk(0,0,0,0,1, 3,0,0,10,1,0,1));
        tab.push_back(mk(0,0,0,0,1, 3,0,0,10,1,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0));
        // flush bubble, then rst mid-stall
        tab.push_back(mk(0,0,0,1,1, 0,0,0, 7,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 7,0,0, 2,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 2,0,0, 1,1,0,1));
        tab.push_back(mk(1,0,0,0,1, 2,0,0, 1,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 2,0,0, 1,1,0,0));
        // r15 tracked, second source
        tab.push_back(mk(0,0,0,0,1, 0,0,0,15,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 1,15,1,0,0,0,1));
        tab.push_back(mk(0,0,0,0,1, 1,15,1,0,0,0,1));
        tab.push_back(mk(0,0,0,0,1, 1,15,1,0,0,0,0));
        tab.push_back(mk(0,0,0,0,1, 0,0,0, 0,0,0,0));

        foreach (tab[i]) step(tab[i], 1, $sformatf("vec%0d", i));

`ifdef HAZARD_STALL_COUNTER_EN
        step(mk(1,0,0,0,0, 0,0,0, 0,0,0,0), 0, "cnt_rst");
        for (int i = 0; i < 31; i++)
            step(mk(0,0,0,0,1, 3,0,0, 3,1,0,0), 0, "cnt_run");
        step(mk(0,0,1,0,1, 0,0,0, 3,1,0,0), 0, "cnt_frz");
        check("cnt_sat", {28'd0, stallCount}, 15);
`endif

        step(mk(1,0,0,0,0, 0,0,0, 0,0,0,0), 0, "rnd_rst");
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v = mk(($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                   ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 5) != 0), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, 1), 0);
            step(v, 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
